sig_round_stage: RTL and testbench

SIG_ROUND_STAGE -- requirements
Module: sig_round_stage

---
 rtl/fpu_pkg.sv | 19 +
 rtl/sig_round_stage_rnd_decide.sv | 27 ++
 rtl/sig_round_stage.sv | 123 ++++++++++++
 tb/tb_sig_round_stage.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU rounding definitions: rounding modes, precision widths and
// significand field positions within the pre-round operand.
package fpu_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RZ  = 2'b01,
    RM_RU  = 2'b10,
    RM_RD  = 2'b11
  } rm_e;

  localparam int unsigned E_W     = 11;
  localparam int unsigned F_W     = 56;
  localparam int unsigned DBL_W   = 53;
  localparam int unsigned SGL_W   = 24;
  localparam int unsigned DBL_LSB = 3;
  localparam int unsigned SGL_LSB = 32;

endpackage

// File: rtl/sig_round_stage_rnd_decide.sv
// Rounding decision: from lsb/guard/sticky, mode and sign decide whether to
// increment the significand and whether the result is inexact.
module rnd_decide
  import fpu_pkg::*;
(
  input  logic       lsb,
  input  logic       g,
  input  logic       st,
  input  logic [1:0] rm,
  input  logic       sign,
  output logic       inc,
  output logic       inx
);

  always_comb begin
    inx = g | st;
    inc = 1'b0;
    case (rm_e'(rm))
      RM_RNE:  inc = g & (st | lsb);
      RM_RZ:   inc = 1'b0;
      RM_RU:   inc = ~sign & inx;
      RM_RD:   inc = sign & inx;
      default: inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/sig_round_stage.sv
// Two-stage significand rounding pipeline with valid/ready handshakes.
// Define FPU_RND_STATS_EN to add saturating inexact/overflow counters.
module sig_round_stage
  import fpu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic             in_db,
  input  logic [1:0]       in_rm,
  input  logic [E_W-1:0]   in_e1,
  input  logic [F_W-1:0]   in_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic             out_db,
  output logic [E_W-1:0]   out_e2,
  output logic [DBL_W-1:0] out_f2,
  output logic             out_sigovf,
`ifdef FPU_RND_STATS_EN
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_inx_cnt,
  output logic [CNT_W-1:0] stat_ovf_cnt,
`endif
  output logic             out_inx
);

  localparam logic [DBL_W:0] DBL_ULP = (DBL_W+1)'(1);
  localparam logic [DBL_W:0] SGL_ULP = (DBL_W+1)'(1) << (DBL_W - SGL_W);

  logic             s1_valid;
  logic             s1_sign;
  logic             s1_db;
  logic [E_W-1:0]   s1_e1;
  logic [DBL_W-1:0] s1_sig;
  logic             s1_inc;
  logic             s1_inx;
  logic             s2_ready;

  logic             lsb, g, st, inc, inx;
  logic [DBL_W-1:0] in_sig;
  logic [DBL_W:0]   sum;
  logic             ovf;
  logic [DBL_W-1:0] f2;

  assign s2_ready = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_ready;

  // Single significands are left-aligned in the 53-bit field so one adder
  // and one carry-out serve both precisions.
  always_comb begin
    lsb    = in_db ? in_f[DBL_LSB]     : in_f[SGL_LSB];
    g      = in_db ? in_f[DBL_LSB-1]   : in_f[SGL_LSB-1];
    st     = in_db ? |in_f[DBL_LSB-2:0] : |in_f[SGL_LSB-2:0];
    in_sig = in_db ? in_f[F_W-1:DBL_LSB]
                   : {in_f[F_W-1:SGL_LSB], (DBL_W-SGL_W)'(0)};
  end

  rnd_decide u_rnd_decide (
    .lsb  (lsb),
    .g    (g),
    .st   (st),
    .rm   (in_rm),
    .sign (in_sign),
    .inc  (inc),
    .inx  (inx)
  );

  always_comb begin
    sum = {1'b0, s1_sig} + (s1_inc ? (s1_db ? DBL_ULP : SGL_ULP) : '0);
    ovf = sum[DBL_W];
    f2  = ovf ? {1'b1, (DBL_W-1)'(0)} : sum[DBL_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (in_ready) s1_valid  <= in_valid;
      if (s2_ready) out_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_sign <= in_sign;
      s1_db   <= in_db;
      s1_e1   <= in_e1;
      s1_sig  <= in_sig;
      s1_inc  <= inc;
      s1_inx  <= inx;
    end
    if (s1_valid && s2_ready) begin
      out_sign   <= s1_sign;
      out_db     <= s1_db;
      out_e2     <= s1_e1 + E_W'(ovf);
      out_f2     <= f2;
      out_sigovf <= ovf;
      out_inx    <= s1_inx;
    end
  end

`ifdef FPU_RND_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_inx_cnt <= '0;
      stat_ovf_cnt <= '0;
    end else if (stat_clr) begin
      stat_inx_cnt <= '0;
      stat_ovf_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (out_inx && stat_inx_cnt != '1)    stat_inx_cnt <= stat_inx_cnt + 1'b1;
      if (out_sigovf && stat_ovf_cnt != '1) stat_ovf_cnt <= stat_ovf_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sig_round_stage.sv
// Scoreboard bench for sig_round_stage: random and directed rounding cases
// against an arithmetic reference model, with backpressure and reset.
module tb_sig_round_stage;

  localparam int unsigned CW = 4;

  typedef struct packed {
    logic        sign;
    logic        db;
    logic [10:0] e2;
    logic [52:0] f2;
    logic        ovf;
    logic        inx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic        in_db = 1'b0;
  logic [1:0]  in_rm = 2'b00;
  logic [10:0] in_e1 = '0;
  logic [55:0] in_f = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sign, out_db, out_sigovf, out_inx;
  logic [10:0] out_e2;
  logic [52:0] out_f2;
  logic        stat_clr = 1'b0;
  logic [CW-1:0] stat_inx_cnt, stat_ovf_cnt;

  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 0;
  bit   clr_en = 1'b0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  sig_round_stage #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_db        (in_db),
    .in_rm        (in_rm),
    .in_e1        (in_e1),
    .in_f         (in_f),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sign     (out_sign),
    .out_db       (out_db),
    .out_e2       (out_e2),
    .out_f2       (out_f2),
    .out_sigovf   (out_sigovf),
`ifdef FPU_RND_STATS_EN
    .stat_clr     (stat_clr),
    .stat_inx_cnt (stat_inx_cnt),
    .stat_ovf_cnt (stat_ovf_cnt),
`endif
    .out_inx      (out_inx)
  );

`ifndef FPU_RND_STATS_EN
  assign stat_inx_cnt = '0;
  assign stat_ovf_cnt = '0;
`endif

  // Reference: round the significand as an integer by comparing the
  // discarded remainder against one half ulp.
  function automatic exp_t model(input logic sign, input logic db, input logic [1:0] rm,
                                 input logic [10:0] e1, input logic [55:0] f);
    longint unsigned sig, rem, half;
    int unsigned w;
    bit up, inx, ovf;
    exp_t e;
    if (db) begin
      sig = longint'(f) >> 3; rem = longint'(f) & 64'h7; half = 64'h4; w = 53;
    end else begin
      sig = longint'(f) >> 32; rem = longint'(f) & 64'hFFFF_FFFF; half = 64'h8000_0000; w = 24;
    end
    inx = (rem != 0);
    case (rm)
      2'b00:   up = (rem > half) || (rem == half && (sig & 1) == 1);
      2'b01:   up = 1'b0;
      2'b10:   up = !sign && inx;
      default: up = sign && inx;
    endcase
    sig = sig + longint'(up);
    ovf = (sig == (64'd1 << w));
    if (ovf) sig = 64'd1 << (w - 1);
    e.sign = sign;
    e.db   = db;
    e.e2   = e1 + 11'(ovf);
    e.f2   = db ? 53'(sig) : 53'(sig << 29);
    e.ovf  = ovf;
    e.inx  = inx;
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = !out_ready;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    stat_clr = clr_en && ($urandom_range(0, 15) == 0);
  end

  // Monitor: scoreboard pop, stall stability and counter model.
  bit   prev_stall = 1'b0;
  logic [67:0] saved;
  int unsigned m_inx = 0, m_ovf = 0;
  always @(negedge clk) begin
    exp_t e;
    logic [67:0] cur;
    cur = {out_sign, out_db, out_e2, out_f2, out_sigovf, out_inx};
    if (!rst_n) begin
      prev_stall = 1'b0;
      m_inx = 0;
      m_ovf = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || cur !== saved) begin
          errors++;
          $display("FAIL stall_hold: got v=%b %h, need v=1 %h", out_valid, cur, saved);
        end
      end
`ifdef FPU_RND_STATS_EN
      checks++;
      if (stat_inx_cnt !== CW'(m_inx) || stat_ovf_cnt !== CW'(m_ovf)) begin
        errors++;
        $display("FAIL stat_cnt: got inx=%0d ovf=%0d, need inx=%0d ovf=%0d",
                 stat_inx_cnt, stat_ovf_cnt, m_inx, m_ovf);
      end
`endif
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL out_extra: got unexpected output %h, need none", cur);
        end else begin
          e = sbq.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL out_data: got s=%b db=%b e2=%h f2=%h ovf=%b inx=%b, need s=%b db=%b e2=%h f2=%h ovf=%b inx=%b",
                     out_sign, out_db, out_e2, out_f2, out_sigovf, out_inx,
                     e.sign, e.db, e.e2, e.f2, e.ovf, e.inx);
          end
        end
      end
      if (stat_clr) begin
        m_inx = 0;
        m_ovf = 0;
      end else if (out_valid === 1'b1 && out_ready) begin
        if (out_inx && m_inx < (1 << CW) - 1) m_inx++;
        if (out_sigovf && m_ovf < (1 << CW) - 1) m_ovf++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      saved = cur;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s: got %h, need %h", name, got, need);
    end
  endtask

  // Caller is at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_x(input logic s, input logic db, input logic [1:0] rm,
                        input logic [10:0] e1, input logic [55:0] f, input exp_t e);
    int n = 0;
    in_valid = 1'b1; in_sign = s; in_db = db; in_rm = rm; in_e1 = e1; in_f = f;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL in_ready_timeout: got 0, need 1 within 200 cycles");
      in_valid = 1'b0;
      return;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic db, input logic [1:0] rm,
                      input logic [10:0] e1, input logic [55:0] f);
    send_x(s, db, rm, e1, f, model(s, db, rm, e1, f));
  endtask

  task automatic send_rand();
    logic [55:0] f;
    f = {24'($urandom), $urandom};
    case ($urandom_range(0, 5))
      0: f[55:3] = '1;
      1: f[55:32] = '1;
      2: f[2:0] = 3'b100;
      3: f[31:0] = 32'h8000_0000;
      default: ;
    endcase
    send(1'($urandom), 1'($urandom), 2'($urandom), 11'($urandom), f);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (sbq.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    exp_t e;
    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_out_valid", 64'(out_valid), 64'd1 - 64'd1);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // Double RNE carry into the hidden bit; also checks 2-cycle latency.
    e = '{sign: 1'b0, db: 1'b1, e2: 11'h3FF, f2: 53'h10000000000000, ovf: 1'b1, inx: 1'b1};
    send_x(1'b0, 1'b1, 2'b00, 11'h3FE, {53'h1F_FFFF_FFFF_FFFF, 3'b100}, e);
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_c1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("latency_c2", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    // RNE ties, single RU overflow, RD/RZ truncation.
    e = '{sign: 1'b0, db: 1'b1, e2: 11'h100, f2: 53'h2, ovf: 1'b0, inx: 1'b1};
    send_x(1'b0, 1'b1, 2'b00, 11'h100, {53'h2, 3'b100}, e);
    e = '{sign: 1'b0, db: 1'b1, e2: 11'h100, f2: 53'h4, ovf: 1'b0, inx: 1'b1};
    send_x(1'b0, 1'b1, 2'b00, 11'h100, {53'h3, 3'b100}, e);
    e = '{sign: 1'b0, db: 1'b0, e2: 11'h080, f2: {24'h800000, 29'h0}, ovf: 1'b1, inx: 1'b1};
    send_x(1'b0, 1'b0, 2'b10, 11'h07F, {24'hFFFFFF, 32'h1}, e);
    e = '{sign: 1'b0, db: 1'b1, e2: 11'h200, f2: 53'h1F_FFFF_FFFF_FFFF, ovf: 1'b0, inx: 1'b1};
    send_x(1'b0, 1'b1, 2'b11, 11'h200, {53'h1F_FFFF_FFFF_FFFF, 3'b111}, e);
    e = '{sign: 1'b1, db: 1'b0, e2: 11'h7FF, f2: {24'hABCDEF, 29'h0}, ovf: 1'b0, inx: 1'b1};
    send_x(1'b1, 1'b0, 2'b01, 11'h7FF, {24'hABCDEF, 32'hFFFF_FFFF}, e);
    e = '{sign: 1'b1, db: 1'b1, e2: 11'h000, f2: 53'h10000000000000, ovf: 1'b1, inx: 1'b1};
    send_x(1'b1, 1'b1, 2'b11, 11'h7FF, {53'h1F_FFFF_FFFF_FFFF, 3'b001}, e);
    drain();

    // Back-to-back burst with alternating backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) send_rand();
    drain();

    // Random traffic under random backpressure, counters cleared occasionally.
    rdy_mode = 2;
    clr_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send_rand();
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    drain();
    clr_en = 1'b0;
    rdy_mode = 0;
    for (int i = 0; i < 40; i++) send(1'b0, 1'b1, 2'b10, 11'h001, {53'h1F_FFFF_FFFF_FFFF, 3'b011});
    drain();

    // Reset with two operations in flight.
    rdy_mode = 3;
    @(posedge clk); #1;
    send_rand();
    send_rand();
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_valid", 64'(out_valid), 64'd0);
    check("reset_mid_inx_cnt", 64'(stat_inx_cnt), 64'd0);
    check("reset_mid_ovf_cnt", 64'(stat_ovf_cnt), 64'd0);
    sbq.delete();
    rdy_mode = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    send(1'b0, 1'b0, 2'b00, 11'h055, {24'h123456, 32'h8000_0001});
    drain();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, need completion");
    $fatal(1, "timeout");
  end

endmodule
